// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter: burst-granting arbiter sharing one TX FIFO write port among NUM_REQ requesters
// TXARB_FIXED_PRIO_EN selects lowest-index fixed priority instead of round-robin
module tx_fifo_arbiter #(
  parameter int Data_width = 8,
  parameter int NUM_REQ    = 3,
  parameter int LEN_W      = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*LEN_W-1:0]      REQ_LEN,
  input  logic [NUM_REQ*Data_width-1:0] REQ_DATA,
  input  logic                          FIFO_FULL,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [NUM_REQ-1:0]            DATA_ACK,
  output logic [Data_width-1:0]         WR_DATA,
  output logic                          WR_INC,
  output logic                          BUSY
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [LEN_W-1:0] cnt, cnt_n, len_w;
  logic [IW-1:0] idx, idx_n, win;
  logic hit;
`ifdef TXARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    hit = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (REQ[k]) begin
        win = IW'(k);
        hit = 1'b1;
      end
  end
`else
  logic [IW-1:0] ptr, ptr_n;
  int j;
  // descending scan so the first set request at or after ptr is the last one kept
  always_comb begin
    win = '0;
    hit = 1'b0;
    j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (REQ[j]) begin
        win = IW'(j);
        hit = 1'b1;
      end
    end
  end
  assign ptr_n = (state != BURST && hit) ? (int'(win) == NUM_REQ - 1 ? '0 : win + 1'b1) : ptr;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) ptr <= '0;
    else ptr <= ptr_n;
`endif
  assign len_w    = REQ_LEN[win*LEN_W +: LEN_W];
  assign BUSY     = state == BURST;
  assign WR_INC   = BUSY & ~FIFO_FULL & REQ[idx];
  assign WR_DATA  = WR_INC ? REQ_DATA[idx*Data_width +: Data_width] : '0;
  assign DATA_ACK = WR_INC ? {{(NUM_REQ-1){1'b0}}, 1'b1} << idx : '0;
  always_comb begin
    state_n = state;
    gnt_n   = GNT;
    cnt_n   = cnt;
    idx_n   = idx;
    if (state != BURST) begin
      state_n = hit ? BURST : IDLE;
      gnt_n   = hit ? {{(NUM_REQ-1){1'b0}}, 1'b1} << win : '0;
      cnt_n   = hit ? (len_w == '0 ? LEN_W'(1) : len_w) : cnt;
      idx_n   = hit ? win : idx;
    end else if (!REQ[idx]) begin
      state_n = IDLE;
      gnt_n   = '0;
    end else if (WR_INC) begin
      cnt_n   = cnt - 1'b1;
      state_n = cnt == LEN_W'(1) ? IDLE : BURST;
      gnt_n   = cnt == LEN_W'(1) ? '0 : GNT;
    end
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      GNT   <= '0;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      GNT   <= gnt_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// tb_tx_fifo_arbiter: directed self-checking bench for tx_fifo_arbiter
module tb_tx_fifo_arbiter;
  logic CLK, RST, FIFO_FULL, WR_INC, BUSY;
  logic [2:0] REQ, GNT, DATA_ACK;
  logic [5:0] REQ_LEN;
  logic [23:0] REQ_DATA;
  logic [7:0] WR_DATA;
  int checks = 0, errors = 0;
  logic [2:0] rr_exp [4];
  tx_fifo_arbiter dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_LEN(REQ_LEN), .REQ_DATA(REQ_DATA),
    .FIFO_FULL(FIFO_FULL), .GNT(GNT), .DATA_ACK(DATA_ACK), .WR_DATA(WR_DATA),
    .WR_INC(WR_INC), .BUSY(BUSY)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic idle_out(input string tag);
    check({tag, "_gnt"}, GNT, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_wrinc"}, WR_INC, 0);
  endtask
  initial begin
`ifdef TXARB_FIXED_PRIO_EN
    rr_exp = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    rr_exp = '{3'b001, 3'b010, 3'b001, 3'b010};
`endif
    RST = 1'b0; REQ = '0; REQ_LEN = '0; REQ_DATA = '0; FIFO_FULL = 1'b0;
    #1;
    idle_out("rst");
    check("rst_ack", DATA_ACK, 0);
    check("rst_data", WR_DATA, 0);
    tick; tick;
    RST = 1'b1;
    // two-byte burst to requester 1
    REQ = 3'b010; REQ_LEN[3:2] = 2'd2; REQ_DATA[15:8] = 8'hA5;
    #1;
    idle_out("t1_pre");
    tick;
    check("t1_gnt", GNT, 3'b010);
    check("t1_busy", BUSY, 1);
    check("t1_inc0", WR_INC, 1);
    check("t1_data0", WR_DATA, 8'hA5);
    check("t1_ack0", DATA_ACK, 3'b010);
    tick;
    REQ_DATA[15:8] = 8'h3C;
    #1;
    check("t1_inc1", WR_INC, 1);
    check("t1_data1", WR_DATA, 8'h3C);
    check("t1_ack1", DATA_ACK, 3'b010);
    tick;
    REQ = '0;
    #1;
    idle_out("t1_end");
    // round-robin between 0 and 1, one byte each
    REQ = 3'b011; REQ_LEN = 6'b00_01_01;
    for (int i = 0; i < 4; i++) begin
      tick;
      check($sformatf("t2_gnt%0d", i), GNT, rr_exp[i]);
      check($sformatf("t2_inc%0d", i), WR_INC, 1);
      tick;
      check($sformatf("t2_idle%0d", i), BUSY, 0);
    end
    REQ = '0;
    // back-pressure mid-burst
    REQ = 3'b001; REQ_LEN[1:0] = 2'd2; REQ_DATA[7:0] = 8'h11;
    tick;
    check("t3_gnt", GNT, 3'b001);
    check("t3_data0", WR_DATA, 8'h11);
    tick;
    REQ_DATA[7:0] = 8'h22; FIFO_FULL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t3_full_inc%0d", i), WR_INC, 0);
      check($sformatf("t3_full_ack%0d", i), DATA_ACK, 0);
      check($sformatf("t3_full_data%0d", i), WR_DATA, 0);
      check($sformatf("t3_full_gnt%0d", i), GNT, 3'b001);
      tick;
    end
    FIFO_FULL = 1'b0;
    #1;
    check("t3_inc1", WR_INC, 1);
    check("t3_data1", WR_DATA, 8'h22);
    tick;
    REQ = '0;
    #1;
    idle_out("t3_end");
    // abort of a three-byte burst to requester 2
    REQ = 3'b101; REQ_LEN = 6'b11_00_01; REQ_DATA[23:16] = 8'h77;
    tick;
    check("t4_gnt", GNT, 3'b100);
    check("t4_data0", WR_DATA, 8'h77);
    check("t4_ack0", DATA_ACK, 3'b100);
    tick;
    REQ = 3'b001;
    #1;
    check("t4_drop_inc", WR_INC, 0);
    check("t4_drop_ack", DATA_ACK, 0);
    tick;
    idle_out("t4_abort");
    tick;
    check("t4_gnt0", GNT, 3'b001);
    check("t4_inc0", WR_INC, 1);
    tick;
    REQ = '0;
    // asynchronous reset mid-burst
    REQ = 3'b010; REQ_LEN[3:2] = 2'd3; REQ_DATA[15:8] = 8'h5A;
    tick;
    check("t5_gnt", GNT, 3'b010);
    tick;
    check("t5_inc", WR_INC, 1);
    RST = 1'b0;
    #1;
    idle_out("t5_rst");
    check("t5_rst_ack", DATA_ACK, 0);
    check("t5_rst_data", WR_DATA, 0);
    REQ = 3'b111;
    tick;
    RST = 1'b1;
    tick;
    check("t5_gnt0", GNT, 3'b001);
    REQ = '0;
    tick;
    // zero length behaves as one byte
    REQ = 3'b010; REQ_LEN = 6'b00_00_00; REQ_DATA[15:8] = 8'hE1;
    tick;
    check("t6_gnt", GNT, 3'b010);
    check("t6_data", WR_DATA, 8'hE1);
    tick;
    idle_out("t6_end");
    REQ = '0;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
